enybul_app: RTL and testbench
=============================

ENYBUL_APP -- requirements
Module: enybul_app

Interface
REQ-001 Parameter X_MAX, default 16, largest legal grid column.
REQ-002 Parameter Y_MAX, default 20, largest legal grid row.
REQ-003 clk  input  1  system clock; sole clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 step_en  input  1  one-cycle movement strobe (8 Hz tick synchronised to clk).
REQ-006 enybul_state  input  1  fire request from the enemy tank; level, sampled every clk.
REQ-007 tank_state  input  1  enemy tank alive flag.
REQ-008 enytank_xpos / enytank_ypos  input  5 each  enemy tank grid position.
REQ-009 tank_dir  input  2  enemy tank heading: 00 up, 01 down, 10 left, 11 right.
REQ-010 mytank_xpos / mytank_ypos  input  5 each  player tank grid position.
REQ-011 enybul_state_feedback  output  1  bullet in flight; returned to the enemy tank.
REQ-012 enybul_x / enybul_y  output  5 each  bullet grid position.
REQ-013 enybul_dir  output  2  latched bullet heading, same encoding as tank_dir.
REQ-014 mytank_hit  output  1  one-clk pulse when the bullet strikes the player tank.

Function
REQ-015 FSM states IDLE, FLY, RETIRE; exactly one active.
REQ-016 IDLE: feedback 0; on enybul_state=1 and tank_state=1, latch enytank_xpos/ypos into enybul_x/y, tank_dir into enybul_dir, go to FLY.
REQ-017 Latency: feedback rises the clk after the accepted request; request with tank_state=0 ignored.
REQ-018 FLY: feedback 1; enybul_state ignored (no second bullet, no re-latch).
REQ-019 FLY hit check every clk: enybul_x==mytank_xpos and enybul_y==mytank_ypos -> mytank_hit=1 next clk, go to RETIRE.
REQ-020 FLY on step_en with no hit: move one cell: up y-1, down y+1, left x-1, right x+1.
REQ-021 Edge: step_en with move leaving 0..X_MAX / 0..Y_MAX (up at y=0, down at y=Y_MAX, left at x=0, right at x=X_MAX) -> position unchanged, go to RETIRE; no 5-bit wrap ever.
REQ-022 Hit and step_en in the same clk: hit wins, no move.
REQ-023 Hit checked against the post-move position on the following clk (a move onto the player tank yields mytank_hit one clk later).
REQ-024 RETIRE: feedback 0, lasts exactly one clk, requests ignored, then IDLE.
REQ-025 enybul_x/y/dir hold last values in RETIRE and IDLE until the next launch.
REQ-026 mytank_hit asserted at most one clk per bullet; 0 in IDLE.
REQ-027 tank_state falling during FLY: bullet continues until hit or edge.
REQ-028 step_en in IDLE/RETIRE has no effect.

Reset
REQ-029 rst_n=0 asynchronously forces IDLE, feedback 0, enybul_x 0, enybul_y 0, enybul_dir 00, mytank_hit 0.
REQ-030 Reset mid-flight aborts the bullet; no mytank_hit emitted.
REQ-031 After rst_n release, first launch needs a fresh request sampled in IDLE.

Verification
REQ-032 Tank (3,5) dir 11, request; player (6,5); 3 step_en -> bullet (4,5),(5,5),(6,5); mytank_hit one pulse the clk after (6,5); feedback low 1 clk later.
REQ-033 Tank (16,2) dir 11, request, one step_en -> no move, RETIRE, feedback 1->0, no hit, position holds (16,2).
REQ-034 Tank (0,0) dir 00 request, step_en -> retire at (0,0), y never 31.
REQ-035 In FLY, hold enybul_state=1 and change tank position/dir -> bullet path unaffected; after RETIRE with request held, relaunch from new tank position 2 clk after retire began.
REQ-036 Request with tank_state=0 -> feedback stays 0; player placed on tank cell at launch -> mytank_hit on first FLY clk even with step_en=1 same clk, no move.
REQ-037 rst_n low for 1 clk mid-flight at (7,9) -> all outputs reset values immediately, no hit pulse, IDLE thereafter.

Source files
------------

// File: rtl/enybul_app_if.sv
// rtl/enybul_app_if.sv - enemy bullet handshake/position bundle
interface enybul_app_if;
    logic       step_en;
    logic       enybul_state;
    logic       tank_state;
    logic [4:0] enytank_xpos;
    logic [4:0] enytank_ypos;
    logic [1:0] tank_dir;
    logic [4:0] mytank_xpos;
    logic [4:0] mytank_ypos;
    logic       enybul_state_feedback;
    logic [4:0] enybul_x;
    logic [4:0] enybul_y;
    logic [1:0] enybul_dir;
    logic       mytank_hit;

    modport master (
        output step_en, enybul_state, tank_state, enytank_xpos, enytank_ypos,
               tank_dir, mytank_xpos, mytank_ypos,
        input  enybul_state_feedback, enybul_x, enybul_y, enybul_dir, mytank_hit
    );

    modport slave (
        input  step_en, enybul_state, tank_state, enytank_xpos, enytank_ypos,
               tank_dir, mytank_xpos, mytank_ypos,
        output enybul_state_feedback, enybul_x, enybul_y, enybul_dir, mytank_hit
    );
endinterface

// File: rtl/enybul_app.sv
// rtl/enybul_app.sv - enemy tank bullet: launch, grid flight, edge retire, player hit
module enybul_app #(
    parameter int X_MAX = 16,
    parameter int Y_MAX = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    enybul_app_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FLY, RETIRE} state_t;

    localparam logic [4:0] XM = 5'(X_MAX);
    localparam logic [4:0] YM = 5'(Y_MAX);

    state_t     state_q, state_d;
    logic [4:0] x_q, x_d, y_q, y_d;
    logic [1:0] dir_q, dir_d;
    logic       hit_q, hit_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        hit_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enybul_state && bus.tank_state) begin
                    x_d     = bus.enytank_xpos;
                    y_d     = bus.enytank_ypos;
                    dir_d   = bus.tank_dir;
                    state_d = FLY;
                end
            end
            FLY: begin
                // Hit takes priority over a same-cycle step; a move that lands on
                // the player is caught by this compare on the following cycle.
                if (x_q == bus.mytank_xpos && y_q == bus.mytank_ypos) begin
                    hit_d   = 1'b1;
                    state_d = RETIRE;
                end else if (bus.step_en) begin
                    case (dir_q)
                        2'b00: if (y_q == 5'd0) state_d = RETIRE; else y_d = y_q - 5'd1;
                        2'b01: if (y_q >= YM)   state_d = RETIRE; else y_d = y_q + 5'd1;
                        2'b10: if (x_q == 5'd0) state_d = RETIRE; else x_d = x_q - 5'd1;
                        default: if (x_q >= XM) state_d = RETIRE; else x_d = x_q + 5'd1;
                    endcase
                end
            end
            RETIRE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.enybul_state_feedback = (state_q == FLY);
    assign bus.enybul_x              = x_q;
    assign bus.enybul_y              = y_q;
    assign bus.enybul_dir            = dir_q;
    assign bus.mytank_hit            = hit_q;
endmodule

// File: tb/tb_enybul_app.sv
// tb/tb_enybul_app.sv - scoreboard bench for enybul_app
module tb_enybul_app;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [13:0] sb[$];
    logic [13:0] e;

    typedef struct packed {
        logic        req;
        logic        step;
        logic        alive;
        logic        rstn;
        logic [13:0] exp;
    } vec_t;

    enybul_app_if bus();

    enybul_app #(.X_MAX(16), .Y_MAX(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] pk(input logic fb, input logic [4:0] x, input logic [4:0] y,
                                       input logic [1:0] d, input logic h);
        return {fb, x, y, d, h};
    endfunction

    function automatic logic [13:0] obs();
        return {bus.enybul_state_feedback, bus.enybul_x, bus.enybul_y, bus.enybul_dir, bus.mytank_hit};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input logic [4:0] tx, input logic [4:0] ty, input logic [1:0] td,
                           input logic [4:0] px, input logic [4:0] py);
        bus.enytank_xpos = tx;
        bus.enytank_ypos = ty;
        bus.tank_dir     = td;
        bus.mytank_xpos  = px;
        bus.mytank_ypos  = py;
    endtask

    task automatic test_reset();
        bus.step_en = 0; bus.enybul_state = 1; bus.tank_state = 1;
        set_pos(5'd3, 5'd3, 2'd1, 5'd9, 5'd9);
        rst_n = 0;
        tick();
        tests++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            fails++; $display("FAIL reset_hold: got %h expected %h", obs(), pk(0, 0, 0, 0, 0));
        end
        bus.enybul_state = 0;
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(pk(0, 0, 0, 0, 0));
            tick();
            e = sb.pop_front(); tests++;
            if (obs() !== e) begin
                fails++; $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_hit_path();
        vec_t v[6];
        set_pos(5'd3, 5'd5, 2'd3, 5'd6, 5'd5);
        v = '{'{1, 0, 1, 1, pk(1, 3, 5, 3, 0)},
              '{0, 1, 1, 1, pk(1, 4, 5, 3, 0)},
              '{0, 1, 1, 1, pk(1, 5, 5, 3, 0)},
              '{0, 1, 1, 1, pk(1, 6, 5, 3, 0)},
              '{0, 0, 1, 1, pk(0, 6, 5, 3, 1)},
              '{0, 0, 1, 1, pk(0, 6, 5, 3, 0)}};
        for (int i = 0; i < 6; i++) begin
            bus.enybul_state = v[i].req; bus.step_en = v[i].step;
            bus.tank_state = v[i].alive; rst_n = v[i].rstn;
            sb.push_back(v[i].exp);
            tick();
            e = sb.pop_front(); tests++;
            if (obs() !== e) begin
                fails++; $display("FAIL hit_path[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_edge_right();
        vec_t v[3];
        set_pos(5'd16, 5'd2, 2'd3, 5'd0, 5'd0);
        v = '{'{1, 0, 1, 1, pk(1, 16, 2, 3, 0)},
              '{0, 1, 1, 1, pk(0, 16, 2, 3, 0)},
              '{0, 1, 1, 1, pk(0, 16, 2, 3, 0)}};
        for (int i = 0; i < 3; i++) begin
            bus.enybul_state = v[i].req; bus.step_en = v[i].step;
            bus.tank_state = v[i].alive; rst_n = v[i].rstn;
            sb.push_back(v[i].exp);
            tick();
            e = sb.pop_front(); tests++;
            if (obs() !== e) begin
                fails++; $display("FAIL edge_right[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_edge_up();
        vec_t v[3];
        set_pos(5'd0, 5'd0, 2'd0, 5'd10, 5'd10);
        v = '{'{1, 0, 1, 1, pk(1, 0, 0, 0, 0)},
              '{0, 1, 1, 1, pk(0, 0, 0, 0, 0)},
              '{0, 1, 1, 1, pk(0, 0, 0, 0, 0)}};
        for (int i = 0; i < 3; i++) begin
            bus.enybul_state = v[i].req; bus.step_en = v[i].step;
            bus.tank_state = v[i].alive; rst_n = v[i].rstn;
            sb.push_back(v[i].exp);
            tick();
            e = sb.pop_front(); tests++;
            if (obs() !== e) begin
                fails++; $display("FAIL edge_up[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_refire_held();
        vec_t v[9];
        set_pos(5'd2, 5'd19, 2'd1, 5'd7, 5'd9);
        v = '{'{1, 0, 1, 1, pk(1, 2, 19, 1, 0)},
              '{1, 1, 1, 1, pk(1, 2, 20, 1, 0)},
              '{1, 1, 1, 1, pk(0, 2, 20, 1, 0)},
              '{1, 0, 1, 1, pk(0, 2, 20, 1, 0)},
              '{1, 0, 1, 1, pk(1, 9, 9, 2, 0)},
              '{0, 1, 1, 1, pk(1, 8, 9, 2, 0)},
              '{0, 1, 1, 1, pk(1, 7, 9, 2, 0)},
              '{0, 0, 1, 1, pk(0, 7, 9, 2, 1)},
              '{0, 0, 1, 1, pk(0, 7, 9, 2, 0)}};
        for (int i = 0; i < 9; i++) begin
            if (i == 1) set_pos(5'd9, 5'd9, 2'd2, 5'd7, 5'd9);
            bus.enybul_state = v[i].req; bus.step_en = v[i].step;
            bus.tank_state = v[i].alive; rst_n = v[i].rstn;
            sb.push_back(v[i].exp);
            tick();
            e = sb.pop_front(); tests++;
            if (obs() !== e) begin
                fails++; $display("FAIL refire_held[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_dead_tank_and_launch_hit();
        vec_t v[5];
        set_pos(5'd4, 5'd4, 2'd0, 5'd4, 5'd4);
        v = '{'{1, 0, 0, 1, pk(0, 7, 9, 2, 0)},
              '{1, 1, 0, 1, pk(0, 7, 9, 2, 0)},
              '{1, 0, 1, 1, pk(1, 4, 4, 0, 0)},
              '{0, 1, 1, 1, pk(0, 4, 4, 0, 1)},
              '{0, 1, 1, 1, pk(0, 4, 4, 0, 0)}};
        for (int i = 0; i < 5; i++) begin
            bus.enybul_state = v[i].req; bus.step_en = v[i].step;
            bus.tank_state = v[i].alive; rst_n = v[i].rstn;
            sb.push_back(v[i].exp);
            tick();
            e = sb.pop_front(); tests++;
            if (obs() !== e) begin
                fails++; $display("FAIL dead_launch_hit[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_reset_midflight();
        vec_t v[7];
        set_pos(5'd7, 5'd7, 2'd1, 5'd7, 5'd9);
        v = '{'{1, 0, 1, 1, pk(1, 7, 7, 1, 0)},
              '{0, 1, 1, 1, pk(1, 7, 8, 1, 0)},
              '{0, 1, 0, 1, pk(1, 7, 9, 1, 0)},
              '{0, 1, 0, 0, pk(0, 0, 0, 0, 0)},
              '{0, 0, 1, 1, pk(0, 0, 0, 0, 0)},
              '{0, 0, 1, 1, pk(0, 0, 0, 0, 0)},
              '{1, 0, 1, 1, pk(1, 1, 1, 3, 0)}};
        for (int i = 0; i < 7; i++) begin
            if (i == 1) set_pos(5'd1, 5'd1, 2'd3, 5'd7, 5'd9);
            bus.enybul_state = v[i].req; bus.step_en = v[i].step;
            bus.tank_state = v[i].alive; rst_n = v[i].rstn;
            if (!v[i].rstn) begin
                #1;
                tests++;
                if (obs() !== pk(0, 0, 0, 0, 0)) begin
                    fails++; $display("FAIL reset_async: got %h expected %h", obs(), pk(0, 0, 0, 0, 0));
                end
            end
            sb.push_back(v[i].exp);
            tick();
            e = sb.pop_front(); tests++;
            if (obs() !== e) begin
                fails++; $display("FAIL reset_midflight[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit_path();
        test_edge_right();
        test_edge_up();
        test_refire_held();
        test_dead_tank_and_launch_hit();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
